// File: rtl/abro_pkg.sv
// Shared state encoding for the ABRO channel scheduler.
// One-hot states, 4 bits wide.
package abro_pkg;
  localparam int ST_W = 4;
  typedef logic [ST_W-1:0] st_t;
  localparam st_t WAIT_AB = 4'b0001;
  localparam st_t GOT_A   = 4'b0010;
  localparam st_t GOT_B   = 4'b0100;
  localparam st_t DONE    = 4'b1000;
endpackage

// File: rtl/abro_step.sv
// ABRO next-state core, shared by all channels.
// Pure combinational step of one channel's state.
module abro_step
  import abro_pkg::*;
(
  input  logic [ST_W-1:0] state_i,
  input  logic            a_i,
  input  logic            b_i,
  output logic [ST_W-1:0] next_o,
  output logic            o_o
);

  // One-hot decode of the current state; DONE absorbs A/B.
  always_comb begin
    next_o = state_i;
    case (1'b1)
      state_i[0]: begin
        if (a_i && b_i) next_o = DONE;
        else if (a_i)   next_o = GOT_A;
        else if (b_i)   next_o = GOT_B;
      end
      state_i[1]: if (b_i) next_o = DONE;
      state_i[2]: if (a_i) next_o = DONE;
      default:    next_o = state_i;
    endcase
    o_o = (next_o == DONE) && (state_i != DONE);
  end

endmodule

// File: rtl/abro_channel_scheduler.sv
// Round-robin time-sharing of one ABRO core
// across NUM_CH channels with pending A/B flags.
module abro_channel_scheduler
  import abro_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_CH-1:0]      a_evt,
  input  logic [NUM_CH-1:0]      b_evt,
  input  logic [NUM_CH-1:0]      r_evt,
  output logic [NUM_CH-1:0]      o_pulse,
  output logic [CH_W-1:0]        cur_ch,
  output logic [ST_W*NUM_CH-1:0] ch_state
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  st_t               state_q [NUM_CH];
  st_t               state_d [NUM_CH];
  logic [NUM_CH-1:0] a_pend_q, a_pend_d;
  logic [NUM_CH-1:0] b_pend_q, b_pend_d;
  logic [NUM_CH-1:0] o_pulse_q, o_pulse_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;

  st_t  cur_st;
  st_t  nxt_st;
  logic cur_a;
  logic cur_b;
  logic cur_o;

  assign cur_st = state_q[cur_ch_q];
  assign cur_a  = a_pend_q[cur_ch_q] | a_evt[cur_ch_q];
  assign cur_b  = b_pend_q[cur_ch_q] | b_evt[cur_ch_q];

  abro_step u_step (
    .state_i (cur_st),
    .a_i     (cur_a),
    .b_i     (cur_b),
    .next_o  (nxt_st),
    .o_o     (cur_o)
  );

  // Service the pointed channel, accumulate pends, apply restarts last.
  always_comb begin
    state_d   = state_q;
    a_pend_d  = a_pend_q | a_evt;
    b_pend_d  = b_pend_q | b_evt;
    o_pulse_d = '0;
    cur_ch_d  = cur_ch_q;
    if (enable) begin
      state_d[cur_ch_q]   = nxt_st;
      a_pend_d[cur_ch_q]  = 1'b0;
      b_pend_d[cur_ch_q]  = 1'b0;
      o_pulse_d[cur_ch_q] = cur_o;
      cur_ch_d = (cur_ch_q == LAST) ? '0 : cur_ch_q + CH_W'(1);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_evt[i]) begin
        state_d[i]   = WAIT_AB;
        a_pend_d[i]  = 1'b0;
        b_pend_d[i]  = 1'b0;
        o_pulse_d[i] = 1'b0;
      end
    end
  end

  // State bank, pending flags, pointer and pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '{default: WAIT_AB};
      a_pend_q  <= '0;
      b_pend_q  <= '0;
      o_pulse_q <= '0;
      cur_ch_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_pend_q  <= a_pend_d;
      b_pend_q  <= b_pend_d;
      o_pulse_q <= o_pulse_d;
      cur_ch_q  <= cur_ch_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign ch_state[ST_W*g +: ST_W] = state_q[g];
  end

  assign o_pulse = o_pulse_q;
  assign cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_abro_channel_scheduler.sv
// Scoreboard bench for abro_channel_scheduler.
// Behavioural model predicts each cycle's outputs.
module tb_abro_channel_scheduler;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0]   o;
    logic [4*N-1:0] st;
    logic [1:0]     ptr;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] a_evt = '0;
  logic [N-1:0] b_evt = '0;
  logic [N-1:0] r_evt = '0;
  logic [N-1:0] o_pulse;
  logic [1:0]   cur_ch;
  logic [4*N-1:0] ch_state;

  int checks = 0;
  int errors = 0;
  int pcnt [N];
  exp_t sb [$];

  int ms [N];
  bit ma [N];
  bit mb [N];
  int mp = 0;

  abro_channel_scheduler #(.NUM_CH(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .a_evt    (a_evt),
    .b_evt    (b_evt),
    .r_evt    (r_evt),
    .o_pulse  (o_pulse),
    .cur_ch   (cur_ch),
    .ch_state (ch_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int s);
    return 4'(1 << s);
  endfunction

  // Model codes: 0 wait, 1 got A, 2 got B, 3 done.
  task automatic model(input logic en, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] r,
                       input logic rs);
    exp_t e;
    int s, ns, c;
    e.o = '0;
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        ms[i] = 0; ma[i] = 0; mb[i] = 0;
      end
      mp = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ma[i] = ma[i] | a[i];
        mb[i] = mb[i] | b[i];
      end
      if (en) begin
        c = mp;
        s = ms[c];
        ns = s;
        if (s == 0) ns = (ma[c] && mb[c]) ? 3 : ma[c] ? 1 : mb[c] ? 2 : 0;
        else if (s == 1 && mb[c]) ns = 3;
        else if (s == 2 && ma[c]) ns = 3;
        if (ns == 3 && s != 3) e.o[c] = 1'b1;
        ms[c] = ns;
        ma[c] = 0;
        mb[c] = 0;
        mp = (mp + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          ms[i] = 0; ma[i] = 0; mb[i] = 0;
          e.o[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) e.st[4*i +: 4] = oh(ms[i]);
    e.ptr = 2'(mp);
    sb.push_back(e);
  endtask

  task automatic step(input logic en, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [N-1:0] r,
                      input logic rs);
    exp_t e;
    enable = en; a_evt = a; b_evt = b; r_evt = r; reset = rs;
    model(en, a, b, r, rs);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_o_pulse", 32'(o_pulse), 32'(e.o));
      chk("sb_ch_state", 32'(ch_state), 32'(e.st));
      chk("sb_cur_ch", 32'(cur_ch), 32'(e.ptr));
    end
    for (int i = 0; i < N; i++) pcnt[i] += int'(o_pulse[i]);
  endtask

  task automatic idle();
    step(1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic wait_ch(input int c);
    for (int k = 0; k < N + 1 && int'(cur_ch) != c; k++) idle();
    chk("wait_ch", 32'(cur_ch), 32'(c));
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N; i++) pcnt[i] = 0;
  endtask

  initial begin
    logic [1:0] frz;
    clr_cnt();
    // 1: reset and pointer sequence
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b1, '0, '0, '0, 1'b1);
    chk("rst_state", 32'(ch_state), 32'h1111);
    chk("rst_o", 32'(o_pulse), 32'h0);
    chk("rst_ch", 32'(cur_ch), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk("ptr_seq", 32'(cur_ch), 32'(k % N));
    end
    // 2: A then B on ch0
    clr_cnt();
    wait_ch(2);
    step(1'b1, 4'b0001, '0, '0, 1'b0);
    wait_ch(0);
    idle();
    chk("t2_got_a", 32'(ch_state[3:0]), 32'h2);
    wait_ch(1);
    step(1'b1, '0, 4'b0001, '0, 1'b0);
    wait_ch(0);
    idle();
    chk("t2_done", 32'(ch_state[3:0]), 32'h8);
    chk("t2_pulse", 32'(o_pulse), 32'h1);
    idle();
    chk("t2_pulse_end", 32'(o_pulse), 32'h0);
    chk("t2_cnt", 32'(pcnt[0]), 32'd1);
    // 3: A and B together on ch1
    clr_cnt();
    wait_ch(3);
    step(1'b1, 4'b0010, 4'b0010, '0, 1'b0);
    wait_ch(1);
    chk("t3_pre", 32'(ch_state[7:4]), 32'h1);
    idle();
    chk("t3_done", 32'(ch_state[7:4]), 32'h8);
    chk("t3_pulse", 32'(o_pulse), 32'h2);
    idle(); idle();
    chk("t3_cnt", 32'(pcnt[1]), 32'd1);
    // 4: DONE ignores events; restart then B, A
    clr_cnt();
    for (int k = 0; k < 5; k++) step(1'b1, 4'b0010, 4'b0010, '0, 1'b0);
    chk("t4_hold", 32'(ch_state[7:4]), 32'h8);
    chk("t4_nopulse", 32'(pcnt[1]), 32'd0);
    step(1'b1, '0, '0, 4'b0010, 1'b0);
    chk("t4_restart", 32'(ch_state[7:4]), 32'h1);
    step(1'b1, '0, 4'b0010, '0, 1'b0);
    wait_ch(1);
    idle();
    chk("t4_got_b", 32'(ch_state[7:4]), 32'h4);
    step(1'b1, 4'b0010, '0, '0, 1'b0);
    wait_ch(1);
    idle();
    chk("t4_done", 32'(ch_state[7:4]), 32'h8);
    chk("t4_cnt", 32'(pcnt[1]), 32'd1);
    // 5: frozen pointer, pends accumulate
    clr_cnt();
    frz = cur_ch;
    for (int k = 0; k < 10; k++)
      step(1'b0, (k == 2) ? 4'b1000 : 4'b0000,
           (k == 6) ? 4'b1000 : 4'b0000, '0, 1'b0);
    chk("t5_frozen", 32'(cur_ch), 32'(frz));
    chk("t5_nopulse", 32'(pcnt[3]), 32'd0);
    wait_ch(3);
    idle();
    chk("t5_pulse", 32'(o_pulse), 32'h8);
    // 6: restart overrides service of pending ch2
    clr_cnt();
    wait_ch(3);
    step(1'b1, 4'b0100, 4'b0100, '0, 1'b0);
    wait_ch(2);
    step(1'b1, '0, '0, 4'b0100, 1'b0);
    chk("t6_state", 32'(ch_state[11:8]), 32'h1);
    chk("t6_o", 32'(o_pulse), 32'h0);
    for (int k = 0; k < N + 1; k++) idle();
    chk("t6_cnt", 32'(pcnt[2]), 32'd0);
    chk("t6_wait", 32'(ch_state[11:8]), 32'h1);
    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) < 8),
           N'($urandom & $urandom),
           N'($urandom & $urandom),
           ($urandom_range(0, 7) == 0) ? N'($urandom & $urandom) : '0,
           ($urandom_range(0, 59) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
